windowed_reg_file: RTL and testbench

- Register file with a register-window pointer that sits directly downstream of the multicycle control unit.
- Consumes the control unit's reg_write and wind_cond strobes. Supplies the A/B operand latches that the ALU source muxes read.
- Logical register addresses from the instruction are mapped onto a larger physical array through the current window pointer. Adjacent windows overlap so that parameters can be passed between them.

---
 rtl/windowed_reg_file.sv | 67 ++++++
 tb/tb_windowed_reg_file.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/windowed_reg_file.sv
// Windowed register file: logical addresses map onto a shared physical array through the
// current window pointer, with overlapping windows. Define WRF_WRITE_BYPASS_EN to forward same-cycle writes to the operand latches.
module windowed_reg_file #(
  parameter int DATA_W     = 16,
  parameter int NUM_WIN    = 4,
  parameter int WIN_REGS   = 8,
  parameter int WIN_STRIDE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(WIN_REGS)-1:0] rs_addr,
  input  logic [$clog2(WIN_REGS)-1:0] rt_addr,
  input  logic [$clog2(WIN_REGS)-1:0] rd_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        reg_write,
  input  logic                        wind_cond,
  input  logic [$clog2(NUM_WIN)-1:0]  wind_sel,
  output logic [DATA_W-1:0]           a_out,
  output logic [DATA_W-1:0]           b_out,
  output logic [$clog2(NUM_WIN)-1:0]  wp_out,
  output logic                        win_changed
);

  localparam int RAW  = $clog2(WIN_REGS);
  localparam int WPW  = $clog2(NUM_WIN);
  localparam int PHYS = NUM_WIN * WIN_STRIDE;
  localparam int PW   = (PHYS > 1) ? $clog2(PHYS) : 1;

  logic [DATA_W-1:0] regs [PHYS];
  logic [WPW-1:0]    wp;
  logic [PW-1:0]     rs_phys;
  logic [PW-1:0]     rt_phys;
  logic [PW-1:0]     rd_phys;

  // Modulo keeps the top window wrapping onto the bottom of the array; PHYS need not be a power of two.
  function automatic logic [PW-1:0] phys_idx(input logic [WPW-1:0] w, input logic [RAW-1:0] r);
    logic [31:0] sum;
    sum = 32'(w) * 32'(WIN_STRIDE) + 32'(r);
    return PW'(sum % 32'(PHYS));
  endfunction

  assign rs_phys = phys_idx(wp, rs_addr);
  assign rt_phys = phys_idx(wp, rt_addr);
  assign rd_phys = phys_idx(wp, rd_addr);
  assign wp_out  = wp;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHYS; i++) regs[i] <= '0;
      wp          <= '0;
      a_out       <= '0;
      b_out       <= '0;
      win_changed <= 1'b0;
    end else begin
      a_out <= regs[rs_phys];
      b_out <= regs[rt_phys];
`ifdef WRF_WRITE_BYPASS_EN
      if (reg_write && (rd_phys == rs_phys)) a_out <= wr_data;
      if (reg_write && (rd_phys == rt_phys)) b_out <= wr_data;
`endif
      if (reg_write) regs[rd_phys] <= wr_data;
      win_changed <= wind_cond;
      if (wind_cond) wp <= wind_sel;
    end
  end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Bench for windowed_reg_file: directed literal checks from the test plan plus randomized
// traffic compared every cycle against a behavioural array model.
module tb_windowed_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] wr_data;
  logic        reg_write, wind_cond;
  logic [1:0]  wind_sel;
  logic [15:0] a_out, b_out;
  logic [1:0]  wp_out;
  logic        win_changed;

  int tests  = 0;
  int failed = 0;
  bit chk_en = 0;

  int          m_regs [16];
  int          m_wp;
  logic [15:0] exp_a, exp_b;
  logic        exp_wc;

  windowed_reg_file dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .wr_data(wr_data), .reg_write(reg_write), .wind_cond(wind_cond), .wind_sel(wind_sel),
    .a_out(a_out), .b_out(b_out), .wp_out(wp_out), .win_changed(win_changed)
  );

  always #5 clk = ~clk;

  function automatic int phys(input int w, input int r);
    return (w * 4 + r) % 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: window-relative array access with the pre-edge window pointer.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_wp = 0; exp_a = 0; exp_b = 0; exp_wc = 0;
    end else begin
      int pa, pb, pd;
      pa = phys(m_wp, int'(rs_addr));
      pb = phys(m_wp, int'(rt_addr));
      pd = phys(m_wp, int'(rd_addr));
      exp_a = 16'(m_regs[pa]);
      exp_b = 16'(m_regs[pb]);
`ifdef WRF_WRITE_BYPASS_EN
      if (reg_write && pd == pa) exp_a = wr_data;
      if (reg_write && pd == pb) exp_b = wr_data;
`endif
      if (reg_write) m_regs[pd] = int'(wr_data);
      exp_wc = wind_cond;
      if (wind_cond) m_wp = int'(wind_sel);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_a", 32'(a_out), 32'(exp_a));
      chk("model_b", 32'(b_out), 32'(exp_b));
      chk("model_wp", 32'(wp_out), 32'(m_wp));
      chk("model_wc", 32'(win_changed), 32'(exp_wc));
    end
  end

  task automatic cyc(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                     input logic [15:0] wd, input logic we, input logic wc, input logic [1:0] ws);
    rs_addr = rs; rt_addr = rt; rd_addr = rd; wr_data = wd;
    reg_write = we; wind_cond = wc; wind_sel = ws;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; wr_data = 0;
    reg_write = 1'bx; wind_cond = 1'bx; wind_sel = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    cyc(0, 0, 0, 16'h0, 0, 0, 0);
    chk("reset_a", 32'(a_out), 32'h0);
    chk("reset_wp", 32'(wp_out), 32'h0);
    reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      cyc(3'(r), 3'(7 - r), 0, 16'h0, 0, 0, 0);
      chk("win0_read_a", 32'(a_out), 32'h0);
      chk("win0_read_b", 32'(b_out), 32'h0);
      chk("win0_wc", 32'(win_changed), 32'h0);
    end

    // r5 of window 0 aliases r1 of window 1 (physical 5)
    cyc(0, 0, 5, 16'h1234, 1, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 1);
    chk("switch1_wp", 32'(wp_out), 32'h1);
    chk("switch1_wc", 32'(win_changed), 32'h1);
    cyc(1, 5, 0, 16'h0, 0, 0, 0);
    chk("alias_r1", 32'(a_out), 32'h1234);
    chk("pulse_one_cycle", 32'(win_changed), 32'h0);

    // window 3 r6 wraps to physical 2
    cyc(0, 0, 0, 16'h0, 0, 1, 3);
    cyc(0, 0, 6, 16'hBEEF, 1, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    cyc(2, 0, 0, 16'h0, 0, 0, 0);
    chk("wrap_r2", 32'(a_out), 32'hBEEF);

    cyc(0, 0, 3, 16'h00AA, 1, 1, 2);
    chk("simul_wp", 32'(wp_out), 32'h2);
    cyc(3, 3, 0, 16'h0, 0, 0, 0);
    chk("simul_new_win_r3", 32'(a_out), 32'h0);
    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    cyc(3, 0, 0, 16'h0, 0, 0, 0);
    chk("simul_old_win_r3", 32'(a_out), 32'h00AA);

    cyc(0, 0, 2, 16'h0011, 1, 0, 0);
    cyc(2, 2, 2, 16'h0022, 1, 0, 0);
`ifdef WRF_WRITE_BYPASS_EN
    chk("rw_same_a", 32'(a_out), 32'h0022);
    chk("rw_same_b", 32'(b_out), 32'h0022);
`else
    chk("rw_same_a", 32'(a_out), 32'h0011);
    chk("rw_same_b", 32'(b_out), 32'h0011);
`endif
    cyc(2, 0, 0, 16'h0, 0, 0, 0);
    chk("rw_next_a", 32'(a_out), 32'h0022);

    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    chk("same_win_wp", 32'(wp_out), 32'h0);
    chk("same_win_wc", 32'(win_changed), 32'h1);

    cyc(0, 0, 0, 16'h0, 0, 1, 3);
    reset = 1'b1;
    cyc(2, 1, 1, 16'hFFFF, 1, 1, 2);
    reset = 1'b0;
    chk("midreset_wp", 32'(wp_out), 32'h0);
    chk("midreset_wc", 32'(win_changed), 32'h0);
    cyc(2, 1, 0, 16'h0, 0, 0, 0);
    chk("midreset_r2", 32'(a_out), 32'h0);
    chk("midreset_nowrite", 32'(b_out), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)));
    end
    reset = 1'b0;
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
